// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: PC-select codes,
// FSM states, CSR addresses and trap cause codes.
package trap_pkg;

    localparam logic [1:0] RESET = 2'b00;
    localparam logic [1:0] TRAP  = 2'b01;
    localparam logic [1:0] EPC   = 2'b10;
    localparam logic [1:0] NEXT  = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2,
        S_RET  = 2'd3
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;
    localparam logic [3:0] IRQ_SW        = 4'd3;
    localparam logic [3:0] IRQ_TIMER     = 4'd7;
    localparam logic [3:0] IRQ_EXT       = 4'd11;

    // mcause layout: interrupt flag in the MSB, exception code in the low bits
    function automatic logic [31:0] make_cause(input logic intr, input logic [3:0] code);
        return {intr, 27'd0, code};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// EX-stage / fetch-side bundle between the pipeline (master) and the trap
// controller (slave).
interface trap_ctrl_if #(parameter int XLEN = 32);
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            exc_illegal;
    logic            exc_ecall;
    logic            exc_ebreak;
    logic            is_mret;
    logic            irq_ext;
    logic            irq_sw;
    logic            irq_timer;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic [1:0]      pc_src;
    logic [XLEN-1:0] pc_trap;
    logic [XLEN-1:0] mepc;
    logic            flush;

    modport master (
        output ex_valid, ex_pc, exc_illegal, exc_ecall, exc_ebreak, is_mret,
               irq_ext, irq_sw, irq_timer, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, pc_src, pc_trap, mepc, flush
    );

    modport slave (
        input  ex_valid, ex_pc, exc_illegal, exc_ecall, exc_ebreak, is_mret,
               irq_ext, irq_sw, irq_timer, csr_we, csr_addr, csr_wdata,
        output csr_rdata, pc_src, pc_trap, mepc, flush
    );
endinterface

// File: rtl/trap_ctrl_csr.sv
// Trap CSR file (mstatus, mie, mip, mtvec, mepc, mcause) with write path,
// read mux and trap-target decode. Vectored mtvec mode under TRAP_VECTORED_EN.
module trap_csr
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic            mret_take,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_timer,
    output logic [XLEN-1:0] rdata,
    output logic            status_mie,
    output logic [2:0]      mie_en,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] pc_trap
);

    logic            mpie_q;
    logic            mie_q;
    logic [2:0]      mie_en_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtvec_wval;

`ifdef TRAP_VECTORED_EN
    // Reserved modes 1x collapse to direct mode
    assign mtvec_wval = wdata[1] ? (wdata & ~XLEN'(3)) : wdata;
    assign pc_trap    = (mtvec_q[1:0] == 2'b01 && mcause_q[XLEN-1])
                        ? (mtvec_q & ~XLEN'(3)) + (mcause_q << 2)
                        : (mtvec_q & ~XLEN'(3));
`else
    assign mtvec_wval = wdata & ~XLEN'(3);
    assign pc_trap    = mtvec_q;
`endif

    // Trap entry and mret take precedence over a same-cycle CSR write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mpie_q   <= 1'b0;
            mie_q    <= 1'b0;
            mie_en_q <= 3'b000;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (trap_take) begin
                mpie_q <= mie_q;
                mie_q  <= 1'b0;
            end else if (mret_take) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (we && addr == CSR_MSTATUS) begin
                mie_q  <= wdata[3];
                mpie_q <= wdata[7];
            end

            if (we && addr == CSR_MIE)
                mie_en_q <= {wdata[11], wdata[7], wdata[3]};

            if (we && addr == CSR_MTVEC)
                mtvec_q <= mtvec_wval;

            if (trap_take)
                mepc_q <= trap_epc;
            else if (we && addr == CSR_MEPC)
                mepc_q <= wdata & ~XLEN'(3);

            if (trap_take)
                mcause_q <= trap_cause;
            else if (we && addr == CSR_MCAUSE)
                mcause_q <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CSR_MSTATUS: begin
                rdata[3] = mie_q;
                rdata[7] = mpie_q;
            end
            CSR_MIE: begin
                rdata[3]  = mie_en_q[0];
                rdata[7]  = mie_en_q[1];
                rdata[11] = mie_en_q[2];
            end
            CSR_MTVEC:  rdata = mtvec_q;
            CSR_MEPC:   rdata = mepc_q;
            CSR_MCAUSE: rdata = mcause_q;
            CSR_MIP: begin
                rdata[3]  = irq_sw;
                rdata[7]  = irq_timer;
                rdata[11] = irq_ext;
            end
            default:    rdata = '0;
        endcase
    end

    assign status_mie = mie_q;
    assign mie_en     = mie_en_q;
    assign mepc       = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: event priority, accept logic and the
// BOOT/RUN/TRAP/RET sequencer feeding the next-PC selector.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_stall,
    trap_ctrl_if.slave bus
);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            exc_any;
    logic [3:0]      exc_code;
    logic            status_mie;
    logic [2:0]      mie_en;
    logic [2:0]      irq_pend;
    logic            irq_any;
    logic [3:0]      irq_code;
    logic            trap_take;
    logic            mret_take;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_epc;

    assign accept = (state == S_RUN) && bus.ex_valid && !i_stall;

    always_comb begin
        exc_any = bus.exc_illegal | bus.exc_ebreak | bus.exc_ecall;
        if (bus.exc_illegal)
            exc_code = CAUSE_ILLEGAL;
        else if (bus.exc_ebreak)
            exc_code = CAUSE_EBREAK;
        else
            exc_code = CAUSE_ECALL;
    end

    // Pending bits ordered {ext, timer, sw}; ext beats sw beats timer
    assign irq_pend = {bus.irq_ext, bus.irq_timer, bus.irq_sw} & mie_en & {3{status_mie}};

    always_comb begin
        irq_any = |irq_pend;
        if (irq_pend[2])
            irq_code = IRQ_EXT;
        else if (irq_pend[0])
            irq_code = IRQ_SW;
        else
            irq_code = IRQ_TIMER;
    end

    assign trap_take  = accept && (exc_any || irq_any);
    assign mret_take  = accept && bus.is_mret && !exc_any && !irq_any;
    assign trap_cause = exc_any ? make_cause(1'b0, exc_code) : make_cause(1'b1, irq_code);
    assign trap_epc   = bus.ex_pc & ~XLEN'(3);

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: state_nxt = S_RUN;
            S_RUN: begin
                if (trap_take)
                    state_nxt = S_TRAP;
                else if (mret_take)
                    state_nxt = S_RET;
            end
            S_TRAP: state_nxt = S_RUN;
            S_RET:  state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        bus.pc_src = RESET;
        case (state)
            S_BOOT: bus.pc_src = RESET;
            S_RUN:  bus.pc_src = NEXT;
            S_TRAP: bus.pc_src = TRAP;
            S_RET:  bus.pc_src = EPC;
            default: bus.pc_src = RESET;
        endcase
    end

    assign bus.flush = (state == S_TRAP) || (state == S_RET);

    trap_csr #(.XLEN(XLEN)) u_csr (
        .clk        (i_clk),
        .rst        (i_rst),
        .we         (accept && bus.csr_we),
        .addr       (bus.csr_addr),
        .wdata      (bus.csr_wdata),
        .trap_take  (trap_take),
        .trap_cause (trap_cause),
        .trap_epc   (trap_epc),
        .mret_take  (mret_take),
        .irq_ext    (bus.irq_ext),
        .irq_sw     (bus.irq_sw),
        .irq_timer  (bus.irq_timer),
        .rdata      (bus.csr_rdata),
        .status_mie (status_mie),
        .mie_en     (mie_en),
        .mepc       (bus.mepc),
        .pc_trap    (bus.pc_trap)
    );

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed events push expected redirects,
// a negedge monitor pops and compares on every flush cycle.
module tb_trap_ctrl;
    import trap_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic stall;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_stall (stall),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] MTVEC_RB = 32'h81;
    localparam logic [31:0] PCT_EXT  = 32'hAC;
    localparam logic [31:0] PCT_SW   = 32'h8C;
`else
    localparam logic [31:0] MTVEC_RB = 32'h80;
    localparam logic [31:0] PCT_EXT  = 32'h80;
    localparam logic [31:0] PCT_SW   = 32'h80;
`endif

    typedef struct {
        string       name;
        logic [1:0]  pc_src;
        logic [31:0] pc_trap;
        logic [31:0] mepc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [1:0] src,
                            input logic [31:0] trap, input logic [31:0] epc);
        exp_t e;
        e.name = name; e.pc_src = src; e.pc_trap = trap; e.mepc = epc;
        exp_q.push_back(e);
    endtask

    // Every flush cycle must match the next queued redirect
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.flush === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_flush: got pc_src=%0d, expected no flush", bus.pc_src);
            end else begin
                mon_e = exp_q.pop_front();
                check_output({mon_e.name, "_pc_src"}, 32'(bus.pc_src), 32'(mon_e.pc_src));
                check_output({mon_e.name, "_pc_trap"}, bus.pc_trap, mon_e.pc_trap);
                check_output({mon_e.name, "_mepc"}, bus.mepc, mon_e.mepc);
            end
        end
    end

    task automatic clear_inputs();
        bus.ex_valid    = 1'b0;
        bus.ex_pc       = 32'h0;
        bus.exc_illegal = 1'b0;
        bus.exc_ecall   = 1'b0;
        bus.exc_ebreak  = 1'b0;
        bus.is_mret     = 1'b0;
        bus.csr_we      = 1'b0;
        bus.csr_wdata   = 32'h0;
    endtask

    // Present one instruction for 'hold' edges, then let a redirect settle
    task automatic apply_stimulus(input logic [31:0] pc, input logic ill, input logic ebk,
                                  input logic ecl, input logic mret, input int hold);
        @(negedge clk);
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = pc;
        bus.exc_illegal = ill;
        bus.exc_ebreak  = ebk;
        bus.exc_ecall   = ecl;
        bus.is_mret     = mret;
        repeat (hold) @(posedge clk);
        #1;
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data, input logic valid);
        @(negedge clk);
        bus.ex_valid  = valid;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_wdata = data;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic csr_read(input string name, input logic [11:0] addr, input logic [31:0] exp);
        @(negedge clk);
        bus.csr_addr = addr;
        #1;
        check_output(name, bus.csr_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        clear_inputs();
        bus.csr_addr  = 12'h0;
        bus.irq_ext   = 1'b0;
        bus.irq_sw    = 1'b0;
        bus.irq_timer = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_output("boot_pc_src", 32'(bus.pc_src), 32'(RESET));
        check_output("boot_flush", 32'(bus.flush), 32'd0);
        @(negedge clk);
        check_output("run_pc_src", 32'(bus.pc_src), 32'(NEXT));
        csr_read("rst_mstatus", CSR_MSTATUS, 32'h0);
        csr_read("rst_mie", CSR_MIE, 32'h0);
        csr_read("rst_mtvec", CSR_MTVEC, 32'h0);
        csr_read("rst_mepc", CSR_MEPC, 32'h0);
        csr_read("rst_mcause", CSR_MCAUSE, 32'h0);
        csr_read("rst_mip", CSR_MIP, 32'h0);
        csr_read("unimpl", 12'h123, 32'h0);

        // mtvec setup: reserved mode reads as direct, unaccepted write ignored
        csr_write(CSR_MTVEC, 32'h83, 1'b1);
        csr_read("mtvec_mode1x", CSR_MTVEC, 32'h80);
        csr_write(CSR_MTVEC, 32'h81, 1'b1);
        csr_read("mtvec_set", CSR_MTVEC, MTVEC_RB);
        csr_write(CSR_MTVEC, 32'h44, 1'b0);
        csr_read("mtvec_no_valid", CSR_MTVEC, MTVEC_RB);
        csr_write(CSR_MSTATUS, 32'h08, 1'b1);
        csr_read("mstatus_mie", CSR_MSTATUS, 32'h08);

        // Illegal instruction goes to base even in vectored mode
        push_exp("illegal", TRAP, 32'h80, 32'h100);
        apply_stimulus(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        csr_read("illegal_mcause", CSR_MCAUSE, 32'd2);
        csr_read("illegal_mstatus", CSR_MSTATUS, 32'h80);

        push_exp("mret", EPC, 32'h80, 32'h100);
        apply_stimulus(32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        csr_read("mret_mstatus", CSR_MSTATUS, 32'h88);

        // ext + timer together: ext wins
        csr_write(CSR_MIE, 32'hFFF, 1'b1);
        csr_read("mie_mask", CSR_MIE, 32'h888);
        @(negedge clk);
        bus.irq_ext   = 1'b1;
        bus.irq_timer = 1'b1;
        csr_read("mip_lines", CSR_MIP, 32'h880);
        push_exp("irq_ext", TRAP, PCT_EXT, 32'h200);
        apply_stimulus(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        csr_read("irq_ext_mcause", CSR_MCAUSE, 32'h8000000B);
        csr_read("irq_ext_mstatus", CSR_MSTATUS, 32'h80);

        push_exp("mret2", EPC, PCT_EXT, 32'h200);
        apply_stimulus(32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Interrupt held off by stall, taken on first unstalled cycle
        @(negedge clk);
        stall        = 1'b1;
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h400;
        repeat (3) @(posedge clk);
        push_exp("irq_after_stall", TRAP, PCT_EXT, 32'h400);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        clear_inputs();
        @(posedge clk);
        #1;
        csr_read("stall_mcause", CSR_MCAUSE, 32'h8000000B);

        // Illegal beats a pending interrupt
        csr_write(CSR_MSTATUS, 32'h08, 1'b1);
        push_exp("ill_vs_irq", TRAP, 32'h80, 32'h500);
        apply_stimulus(32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        csr_read("ill_vs_irq_mcause", CSR_MCAUSE, 32'd2);

        // mret with sw + timer pending: sw interrupt taken at the mret PC
        @(negedge clk);
        bus.irq_ext = 1'b0;
        bus.irq_sw  = 1'b1;
        csr_write(CSR_MSTATUS, 32'h08, 1'b1);
        push_exp("mret_irq", TRAP, PCT_SW, 32'h600);
        apply_stimulus(32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        csr_read("mret_irq_mcause", CSR_MCAUSE, 32'h80000003);
        csr_read("mret_irq_mstatus", CSR_MSTATUS, 32'h80);

        // Exception priority and PC alignment
        push_exp("ebreak_ecall", TRAP, 32'h80, 32'h700);
        apply_stimulus(32'h700, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        csr_read("ebreak_mcause", CSR_MCAUSE, 32'd3);
        push_exp("ecall", TRAP, 32'h80, 32'h704);
        apply_stimulus(32'h707, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        csr_read("ecall_mcause", CSR_MCAUSE, 32'd11);

        // Event still present during TRAP is ignored
        @(negedge clk);
        bus.irq_sw    = 1'b0;
        bus.irq_timer = 1'b0;
        push_exp("held_illegal", TRAP, 32'h80, 32'h800);
        apply_stimulus(32'h800, 1'b1, 1'b0, 1'b0, 1'b0, 2);

        // Reset asserted in the TRAP cycle
        @(negedge clk);
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = 32'h900;
        bus.exc_illegal = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
        check_output("pre_rst_pc_src", 32'(bus.pc_src), 32'(TRAP));
        rst = 1'b1;
        #1;
        check_output("trap_rst_pc_src", 32'(bus.pc_src), 32'(RESET));
        check_output("trap_rst_mepc", bus.mepc, 32'h0);
        check_output("trap_rst_flush", 32'(bus.flush), 32'd0);
        csr_read("trap_rst_mtvec", CSR_MTVEC, 32'h0);
        csr_read("trap_rst_mcause", CSR_MCAUSE, 32'h0);
        csr_read("trap_rst_mie", CSR_MIE, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_pc_src", 32'(bus.pc_src), 32'(NEXT));

        @(negedge clk);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller that drives the PC-select side of the fetch stage. It detects exceptions, interrupts and `mret` at the execute stage and owns the trap CSRs (`mstatus`, `mie`, `mip`, `mtvec`, `mepc`, `mcause`). It produces `pc_src`, `pc_trap` and `mepc` for the next-PC selector, plus a pipeline flush.

## Interface
- `XLEN`, 32: data/address width.
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX holds a real, unflushed instruction.
- `ex_pc`  in  32  PC of the EX instruction.
- `i_stall`  in  1  pipeline hazard stall; EX does not advance.
- `exc_illegal`, `exc_ecall`, `exc_ebreak`  in  1 each  exception flags from EX.
- `is_mret`  in  1  EX instruction is `mret`.
- `irq_ext`, `irq_sw`, `irq_timer`  in  1 each  level-sensitive interrupt lines.
- `csr_we`  in  1  CSR write strobe from EX.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  CSR write data.
- `csr_rdata`  out  32  combinational CSR read data; 0 for unimplemented addresses.
- `pc_src`  out  2  00 RESET, 01 TRAP, 10 EPC, 11 NEXT.
- `pc_trap`  out  32  trap target.
- `mepc`  out  32  return address.
- `flush`  out  1  flush IF/ID/EX.

## Operation
- FSM states:
  - BOOT: reset state, `pc_src`=00.
  - RUN: `pc_src`=11.
  - TRAP: `pc_src`=01, `flush`=1.
  - RET: `pc_src`=10, `flush`=1.
- BOOT -> RUN unconditionally after one cycle.
- TRAP -> RUN and RET -> RUN unconditionally after one cycle, regardless of `i_stall`.
- An event is accepted only in RUN with `ex_valid`=1 and `i_stall`=0.
- Event priority: exception > interrupt > `mret`.
- Exceptions: illegal (cause 2) > ebreak (3) > ecall (11).
- Interrupt pending = `mstatus.MIE` & `mie[k]` & `mip[k]`. Interrupt priority: ext (11) > sw (3) > timer (7).
- Trap entry, registered on the accepting edge:
  - `mepc` <= `ex_pc` with bits [1:0] forced to 0.
  - `mcause` <= {interrupt bit, 0, code}.
  - MPIE <= MIE, MIE <= 0.
  - Next state TRAP.
- `mret`: MIE <= MPIE, MPIE <= 1; next state RET.
- `mret` with an enabled interrupt pending: the interrupt is taken and `mepc` = PC of the `mret`.
- Events presented while in TRAP or RET are ignored; the flushed instruction re-enters later.
- CSR addresses:
  - `mstatus` 0x300: only MIE (bit 3) and MPIE (bit 7) are implemented.
  - `mie` 0x304: bits 3, 7 and 11 are writable.
  - `mtvec` 0x305.
  - `mepc` 0x341.
  - `mcause` 0x342.
  - `mip` 0x344: read-only, reflects the irq lines.
- A CSR write is ignored unless it is accepted under the same conditions as an event.
- When a CSR write and a trap entry or `mret` occur in the same cycle, the trap or `mret` update wins for `mstatus`, `mepc` and `mcause`.
- `pc_trap` = `mtvec` base ({`mtvec`[31:2], 2'b00}) unless vectored (see Configuration).

## Timing
- Reset values:
  - State BOOT, `pc_src`=00, `flush`=0.
  - `mtvec`, `mepc`, `mcause`, `mstatus` and `mie` all 0.
  - `csr_rdata` follows address decode.
- Event accepted at edge N: `pc_src`=01 or 10 and `flush`=1 during cycle N+1. `pc_src`=11 from N+2.
- `pc_src`, `flush` and `pc_trap` are decoded from registered state and CSRs only; they have no combinational path from the event inputs.
- `mepc` output equals the register and is valid from cycle N+1.
- Reset asserted mid-TRAP or mid-RET: immediate return to BOOT with all CSRs cleared.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - `mtvec`[1:0] writable; values 1x read back as 00.
  - With mode 01 and an interrupt trap: `pc_trap` = base + 4·code.
  - Exceptions always go to base.
- Not defined: `mtvec`[1:0] hardwired 00 and `pc_trap` = base always.

## Structure
- Package `trap_pkg` holds:
  - the `pc_src` localparams RESET, TRAP, EPC and NEXT;
  - the FSM state enum;
  - the CSR address constants;
  - the cause codes.
- Sub-module `trap_csr`: CSR registers, the write path and the read mux. The FSM and priority logic stay in `trap_ctrl`.

## Test plan
- Reset release: `pc_src`=00 for one cycle, then 11; `csr_rdata` = 0 for every CSR.
- Illegal instruction at `ex_pc`=0x100 with `mtvec`=0x80: next cycle `pc_src`=01, `pc_trap`=0x80, `flush`=1, `mepc`=0x100, `mcause`=2, MIE=0.
- `mret` after that trap, with MPIE=1: next cycle `pc_src`=10, `mepc`=0x100, `flush`=1; MIE=1 afterwards.
- MIE=1, `mie`=0x888, `irq_timer` and `irq_ext` raised together, `ex_pc`=0x200: `mcause`=0x8000000B, `mepc`=0x200; with `TRAP_VECTORED_EN` and `mtvec`=0x81, `pc_trap`=0xAC.
- Interrupt pending while `i_stall`=1: no trap; it is taken on the first cycle with `i_stall`=0. Same-cycle illegal + interrupt: `mcause`=2.
- Reset asserted during TRAP: `pc_src`=00 and `mepc`=0 immediately.
